ehgu_word_packer: RTL

Downstream consumer of the ehgu_fifo read port. It packs RATIO consecutive DWIDTH-bit FIFO words into one OWIDTH-bit word and presents that word on a valid/ready output interface. It drives the FIFO read enable (en) as back-pressure. A flush request emits a partially filled word with a lane keep mask, used at end of burst.

---
 rtl/ehgu_pack_pkg.sv | 24 ++
 rtl/ehgu_hold_reg.sv | 57 +++++
 rtl/ehgu_word_packer.sv | 100 ++++++++++
 3 files changed

// File: rtl/ehgu_pack_pkg.sv
// Shared helpers for the ehgu word packer: counter sizing and lane keep masks.
package ehgu_pack_pkg;

  localparam int unsigned MAX_RATIO = 16;

  // Width of a counter that must hold the values 0..ratio inclusive.
  function automatic int unsigned cnt_w(input int unsigned ratio);
    return $clog2(ratio + 1);
  endfunction

  // Low `lanes` bits set, never beyond `ratio` lanes.
  function automatic logic [MAX_RATIO-1:0] keep_mask(input int unsigned lanes,
                                                     input int unsigned ratio);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      if (i < lanes && i < ratio) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/ehgu_hold_reg.sv
// One-entry valid/ready output register; loads only when out_free is high.
module ehgu_hold_reg
  import ehgu_pack_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] data,
  input  logic [KW-1:0] keep,
  input  logic          dout_ready,
  output logic [DW-1:0] dout,
  output logic [KW-1:0] dout_keep,
  output logic          dout_valid,
  output logic          out_free
);

  logic [DW-1:0] dout_q, dout_d;
  logic [KW-1:0] keep_q, keep_d;
  logic          valid_q, valid_d;

  // Register is free when empty or being drained this cycle.
  assign out_free   = !valid_q || dout_ready;
  assign dout       = dout_q;
  assign dout_keep  = keep_q;
  assign dout_valid = valid_q;

  // Load a new word, otherwise drop valid once the sink takes the word.
  always_comb begin
    dout_d  = dout_q;
    keep_d  = keep_q;
    valid_d = valid_q;
    if (load) begin
      dout_d  = data;
      keep_d  = keep;
      valid_d = 1'b1;
    end else if (dout_ready) begin
      valid_d = 1'b0;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      keep_q  <= keep_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/ehgu_word_packer.sv
// Packs RATIO consecutive FIFO words into one wide word; flush emits a partial word.
module ehgu_word_packer
  import ehgu_pack_pkg::*;
#(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned RATIO  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     en,
  input  logic                     din_valid,
  input  logic [DWIDTH-1:0]        din,
  input  logic                     flush,
  output logic [DWIDTH*RATIO-1:0]  dout,
  output logic [RATIO-1:0]         dout_keep,
  output logic                     dout_valid,
  input  logic                     dout_ready
);

  localparam int unsigned OWIDTH = DWIDTH * RATIO;
  localparam int unsigned CNT_W  = cnt_w(RATIO);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RATIO);

  logic [OWIDTH-1:0] acc_q, acc_d, acc_wr;
  logic [CNT_W-1:0]  acc_cnt_q, acc_cnt_d;
  logic              flush_pend_q, flush_pend_d;

  logic              out_free;
  logic              accept;
  logic              fill;
  logic              flush_exec;
  logic              move;
  logic [CNT_W-1:0]  move_lanes;
  logic              load;
  logic [RATIO-1:0]  load_keep;

  // Back-pressure, lane write, move decision and next accumulator state.
  always_comb begin
    en         = !flush_pend_q && !(acc_cnt_q == FULL && !out_free);
    accept     = din_valid && en;

    acc_wr = acc_q;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (accept && acc_cnt_q == CNT_W'(i)) begin
        acc_wr[i*DWIDTH +: DWIDTH] = din;
      end
    end

    // A full accumulator moves before taking a new word, which lands in lane 0.
    fill       = (acc_cnt_q == FULL) || (accept && acc_cnt_q == FULL - CNT_W'(1));
    flush_exec = flush_pend_q && out_free;
    move       = out_free && (fill || flush_exec);
    move_lanes = fill ? FULL : acc_cnt_q;
    load       = move && (move_lanes != '0);
    load_keep  = RATIO'(keep_mask(32'(move_lanes), RATIO));

    acc_d     = acc_wr;
    acc_cnt_d = acc_cnt_q + CNT_W'(accept);
    if (move) begin
      acc_d     = '0;
      acc_cnt_d = '0;
      if (accept && acc_cnt_q == FULL) begin
        acc_d[DWIDTH-1:0] = din;
        acc_cnt_d         = CNT_W'(1);
      end
    end

    flush_pend_d = flush_exec ? flush : (flush_pend_q || flush);
  end

  // Accumulator and flush request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      acc_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      acc_cnt_q    <= acc_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  ehgu_hold_reg #(
    .DW (OWIDTH),
    .KW (RATIO)
  ) u_hold (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (acc_wr),
    .keep       (load_keep),
    .dout_ready (dout_ready),
    .dout       (dout),
    .dout_keep  (dout_keep),
    .dout_valid (dout_valid),
    .out_free   (out_free)
  );

endmodule
